mul_uart_engine: RTL and testbench

Parametrised byte-stream multiply engine placed between `uart_rx` and `uart_tx`. It receives a command byte and two multi-byte operands from the receiver and multiplies them, signed or unsigned, with a sequential shift-add datapath. It then streams the double-width product back through the transmitter using its start/ready handshake. It adds operand width, signed mode, framing, an inter-byte timeout and error accounting to the current fixed 8-bit combinational path.

---
 rtl/mul_uart_engine.sv | 169 ++++++++++++++++
 tb/tb_mul_uart_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_uart_engine.sv
// Byte-stream multiply engine between uart_rx and uart_tx: takes a command byte and two
// LSB-first operands, multiplies them by shift-add, and streams the 2W-bit product out LSB first.
module mul_uart_engine #(
    parameter int OP_BYTES    = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk_int,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam int W  = 8 * OP_BYTES;
    localparam int PW = 2 * W;
    localparam int IW = $clog2(2 * OP_BYTES + 1);
    localparam int CW = $clog2(W + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IW-1:0] LAST_OP  = IW'(OP_BYTES - 1);
    localparam logic [IW-1:0] LAST_PB  = IW'(2 * OP_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] ITER     = CW'(W);
    localparam logic [7:0]    CMD_U    = 8'hA5;
    localparam logic [7:0]    CMD_S    = 8'hA6;

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, PREP, MUL, FIX, SEND, SEND_WAIT
    } state_t;

    state_t        state;
    logic          signed_mode;
    logic          neg;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [PW-1:0] mcand;
    logic [PW-1:0] acc;
    logic [IW-1:0] idx;
    logic [CW-1:0] iter;
    logic [TW-1:0] tmo;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Magnitude of the most negative value wraps to 2^(W-1), which is correct read as unsigned.
    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v);
        return (v < 0) ? W'(-v) : W'(v);
    endfunction

    always_ff @(posedge clk_int) begin
        if (!reset) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            err_cnt     <= 8'h00;
            signed_mode <= 1'b0;
            neg         <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            mcand       <= '0;
            acc         <= '0;
            idx         <= '0;
            iter        <= '0;
            tmo         <= '0;
        end else begin
            tx_start <= 1'b0;

            // Bytes arriving while computing or sending are dropped and counted.
            if (rx_valid && !(state inside {IDLE, GET_A, GET_B}))
                err_cnt <= sat_inc(err_cnt);

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_U || rx_data == CMD_S) begin
                            signed_mode <= (rx_data == CMD_S);
                            idx         <= '0;
                            tmo         <= '0;
                            busy        <= 1'b1;
                            state       <= GET_A;
                        end else begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                    end
                end

                GET_A, GET_B: begin
                    if (rx_valid) begin
                        tmo <= '0;
                        for (int i = 0; i < OP_BYTES; i++) begin
                            if (idx == IW'(i)) begin
                                if (state == GET_A) op_a[i*8 +: 8] <= rx_data;
                                else                op_b[i*8 +: 8] <= rx_data;
                            end
                        end
                        if (idx == LAST_OP) begin
                            idx   <= '0;
                            state <= (state == GET_A) ? GET_B : PREP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (tmo == TMO_LAST) begin
                        err_cnt <= sat_inc(err_cnt);
                        idx     <= '0;
                        tmo     <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                PREP: begin
                    neg   <= signed_mode & (op_a[W-1] ^ op_b[W-1]);
                    mcand <= {{W{1'b0}}, (signed_mode ? magnitude(op_a) : op_a)};
                    op_b  <= signed_mode ? magnitude(op_b) : op_b;
                    acc   <= '0;
                    iter  <= ITER;
                    state <= MUL;
                end

                MUL: begin
                    if (op_b[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    op_b  <= op_b >> 1;
                    iter  <= iter - 1'b1;
                    if (iter == CW'(1)) state <= FIX;
                end

                FIX: begin
                    if (neg) acc <= -acc;
                    idx   <= '0;
                    state <= SEND;
                end

                SEND: begin
                    if (tx_ready) begin
                        for (int i = 0; i < 2 * OP_BYTES; i++) begin
                            if (idx == IW'(i)) tx_data <= acc[i*8 +: 8];
                        end
                        tx_start <= 1'b1;
                        state    <= SEND_WAIT;
                    end
                end

                // tx_ready still reads high here; it only drops the cycle after tx_start.
                SEND_WAIT: begin
                    if (idx == LAST_PB) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= SEND;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_uart_engine.sv
// Directed bench for mul_uart_engine: an 8-bit and a 16-bit instance, each behind a simple
// transmitter model that captures every launched byte.
module tb_mul_uart_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       v8 = 1'b0, v16 = 1'b0;
    logic       rdy8 = 1'b1, rdy16 = 1'b1;
    logic       hold8 = 1'b0, hold16 = 1'b0;
    logic       st8, st16, busy8, busy16;
    logic [7:0] d8, d16, err8, err16;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int cnt8  = 0, cnt16 = 0;
    int lat;
    logic [7:0] cap8[$];
    logic [7:0] cap16[$];

    mul_uart_engine #(.OP_BYTES(1), .TIMEOUT_CYC(50)) u8 (
        .clk_int(clk), .reset(reset), .rx_data(rx_data), .rx_valid(v8),
        .tx_ready(rdy8), .tx_start(st8), .tx_data(d8), .busy(busy8), .err_cnt(err8)
    );

    mul_uart_engine #(.OP_BYTES(2), .TIMEOUT_CYC(50)) u16 (
        .clk_int(clk), .reset(reset), .rx_data(rx_data), .rx_valid(v16),
        .tx_ready(rdy16), .tx_start(st16), .tx_data(d16), .busy(busy16), .err_cnt(err16)
    );

    // Transmitter models: ready drops the cycle after tx_start and stays low for a few cycles.
    always @(posedge clk) begin
        if (st8) begin
            rdy8 <= 1'b0;
            cnt8 <= 3;
            cap8.push_back(d8);
        end else if (cnt8 > 0) cnt8 <= cnt8 - 1;
        else rdy8 <= !hold8;

        if (st16) begin
            rdy16 <= 1'b0;
            cnt16 <= 3;
            cap16.push_back(d16);
        end else if (cnt16 > 0) cnt16 <= cnt16 - 1;
        else rdy16 <= !hold16;
    end

    always @(negedge clk) begin
        if ((st8 && !rdy8) || (st16 && !rdy16)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        if (sel) v16 = 1'b1; else v8 = 1'b1;
        @(negedge clk);
        v8  = 1'b0;
        v16 = 1'b0;
    endtask

    task automatic wait_caps(input bit sel, input int n, input int budget);
        int k = 0;
        while (((sel ? cap16.size() : cap8.size()) < n) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("tx_count", sel ? cap16.size() : cap8.size(), n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_start8", st8, 1'b0);
        check("rst_data8", d8, 8'h00);
        check("rst_busy8", busy8, 1'b0);
        check("rst_err8", err8, 8'h00);
        check("rst_start16", st16, 1'b0);
        check("rst_data16", d16, 8'h00);
        check("rst_busy16", busy16, 1'b0);
        check("rst_err16", err16, 8'h00);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Unsigned 0F x 0F
        send(0, 8'hA5);
        check("busy_rise", busy8, 1'b1);
        send(0, 8'h0F);
        send(0, 8'h0F);
        wait_caps(0, 2, 100);
        check("u_0f_b0", cap8[0], 8'hE1);
        check("u_0f_b1", cap8[1], 8'h00);
        repeat (10) @(negedge clk);
        check("u_0f_err", err8, 8'h00);
        check("u_0f_busy", busy8, 1'b0);

        // Signed -1 x 2 and -128 x -128
        cap8.delete();
        send(0, 8'hA6); send(0, 8'hFF); send(0, 8'h02);
        wait_caps(0, 2, 100);
        check("s_m1x2_b0", cap8[0], 8'hFE);
        check("s_m1x2_b1", cap8[1], 8'hFF);
        cap8.delete();
        send(0, 8'hA6); send(0, 8'h80); send(0, 8'h80);
        wait_caps(0, 2, 100);
        check("s_min_b0", cap8[0], 8'h00);
        check("s_min_b1", cap8[1], 8'h40);

        // 16-bit unsigned FFFF x FFFF with latency check
        send(1, 8'hA5); send(1, 8'hFF); send(1, 8'hFF); send(1, 8'hFF); send(1, 8'hFF);
        lat = 0;
        while (!st16 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("lat16", lat, 19);
        wait_caps(1, 4, 200);
        check("w16_b0", cap16[0], 8'h01);
        check("w16_b1", cap16[1], 8'h00);
        check("w16_b2", cap16[2], 8'hFE);
        check("w16_b3", cap16[3], 8'hFF);

        // Transmitter stall of 500 cycles mid-product
        cap16.delete();
        send(1, 8'hA5); send(1, 8'h34); send(1, 8'h12); send(1, 8'h02); send(1, 8'h00);
        wait_caps(1, 1, 100);
        hold16 = 1'b1;
        repeat (500) @(negedge clk);
        check("hold_count", cap16.size(), 1);
        hold16 = 1'b0;
        wait_caps(1, 4, 200);
        check("hold_b0", cap16[0], 8'h68);
        check("hold_b1", cap16[1], 8'h24);
        check("hold_b2", cap16[2], 8'h00);
        check("hold_b3", cap16[3], 8'h00);
        repeat (20) @(negedge clk);
        check("hold_nodup", cap16.size(), 4);
        check("hold_busy", busy16, 1'b0);
        check("start_while_busy", viol, 0);

        // Error accounting
        repeat (5) @(negedge clk);
        send(0, 8'h3C);
        repeat (2) @(negedge clk);
        check("err_badcmd", err8, 8'h01);
        send(0, 8'hA5); send(0, 8'h12);
        repeat (60) @(negedge clk);
        check("err_timeout", err8, 8'h02);
        check("tmo_idle", busy8, 1'b0);
        cap8.delete();
        send(0, 8'hA5); send(0, 8'h07); send(0, 8'h09);
        send(0, 8'h55);
        wait_caps(0, 2, 100);
        check("mulrx_b0", cap8[0], 8'h3F);
        check("mulrx_b1", cap8[1], 8'h00);
        check("err_mulrx", err8, 8'h03);

        // Reset in the middle of MUL
        cap8.delete();
        send(0, 8'hA5); send(0, 8'h03); send(0, 8'h05);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rmul_start", st8, 1'b0);
        check("rmul_data", d8, 8'h00);
        check("rmul_busy", busy8, 1'b0);
        check("rmul_err", err8, 8'h00);
        repeat (30) @(negedge clk);
        check("rmul_abandon", cap8.size(), 0);

        // Reset in the middle of SEND
        send(0, 8'hA5); send(0, 8'h0F); send(0, 8'h0F);
        wait_caps(0, 1, 100);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rsend_start", st8, 1'b0);
        check("rsend_data", d8, 8'h00);
        check("rsend_busy", busy8, 1'b0);
        check("rsend_err", err8, 8'h00);
        repeat (30) @(negedge clk);
        check("rsend_abandon", cap8.size(), 1);

        cap8.delete();
        send(0, 8'hA5); send(0, 8'h03); send(0, 8'h05);
        wait_caps(0, 2, 100);
        check("post_b0", cap8[0], 8'h0F);
        check("post_b1", cap8[1], 8'h00);
        repeat (20) @(negedge clk);
        check("post_count", cap8.size(), 2);
        check("post_busy", busy8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
